aes_decrypt_sequencer: RTL and testbench

AES_DECRYPT_SEQUENCER -- requirements
Module: aes_decrypt_sequencer

---
 rtl/aes_pkg.sv | 104 ++++++++++
 rtl/aes_inv_round.sv | 40 ++++
 rtl/aes_key_expand_step.sv | 29 ++
 rtl/aes_decrypt_sequencer.sv | 158 +++++++++++++++
 tb/tb_aes_decrypt_sequencer.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 decryption definitions: S-box tables, Rcon, FSM encoding and
// the GF(2^8) helpers used by the key schedule and the inverse round.
package aes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KEYEXP = 3'd1,
        ST_INIT   = 3'd2,
        ST_ROUND  = 3'd3,
        ST_DONE   = 3'd4
    } aes_state_e;

    // Byte 0 of each table sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Rcon for rounds 1..10, round 1 in the most significant byte.
    localparam logic [79:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [3:0] k;
        k = 4'd10 - i;
        if ((i >= 4'd1) && (i <= 4'd10)) begin
            return RCON[{k, 3'b000} +: 8];
        end else begin
            return 8'h00;
        end
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Shift-and-add multiply for the small InvMixColumns constants.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] m);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h00;
        for (int i = 0; i < 4; i++) begin
            r = r ^ (p & {8{m[i]}});
            p = xtime(p);
        end
        return r;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = gf_mul(a0, 4'd14) ^ gf_mul(a1, 4'd11) ^ gf_mul(a2, 4'd13) ^ gf_mul(a3, 4'd9);
        b1 = gf_mul(a0, 4'd9)  ^ gf_mul(a1, 4'd14) ^ gf_mul(a2, 4'd11) ^ gf_mul(a3, 4'd13);
        b2 = gf_mul(a0, 4'd13) ^ gf_mul(a1, 4'd9)  ^ gf_mul(a2, 4'd14) ^ gf_mul(a3, 4'd11);
        b3 = gf_mul(a0, 4'd11) ^ gf_mul(a1, 4'd13) ^ gf_mul(a2, 4'd9)  ^ gf_mul(a3, 4'd14);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_inv_round.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey and an
// optional InvMixColumns (skipped for the final round).
module aes_inv_round
    import aes_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    input  logic         mix_en,
    output logic [127:0] state_out
);

    logic [7:0]   in_b_s [16];
    logic [7:0]   sh_b_s [16];
    logic [127:0] added_s;
    logic [127:0] mixed_s;

    // Byte index is 4*column + row; row r is rotated right by r columns.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            in_b_s[i] = state_in[8*(15-i) +: 8];
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sh_b_s[4*c+r] = inv_sbox(in_b_s[4*((c - r + 4) % 4) + r]);
            end
        end
        for (int i = 0; i < 16; i++) begin
            added_s[8*(15-i) +: 8] = sh_b_s[i] ^ round_key[8*(15-i) +: 8];
        end
        for (int c = 0; c < 4; c++) begin
            mixed_s[32*(3-c) +: 32] = inv_mix_column(added_s[32*(3-c) +: 32]);
        end
        if (mix_en) begin
            state_out = mixed_s;
        end else begin
            state_out = added_s;
        end
    end

endmodule

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-schedule step: derives round key i from round key i-1.
module aes_key_expand_step
    import aes_pkg::*;
(
    input  logic [127:0] prev_key,
    input  logic [3:0]   round_idx,
    output logic [127:0] next_key
);

    logic [31:0] w3_s;
    logic [31:0] temp_s;
    logic [31:0] n0_s;
    logic [31:0] n1_s;
    logic [31:0] n2_s;
    logic [31:0] n3_s;

    // RotWord, SubWord and Rcon on the last word, then the running XOR chain.
    always_comb begin
        w3_s   = prev_key[31:0];
        temp_s = {sbox(w3_s[23:16]), sbox(w3_s[15:8]), sbox(w3_s[7:0]), sbox(w3_s[31:24])};
        temp_s = temp_s ^ {rcon(round_idx), 24'h000000};
        n0_s   = prev_key[127:96] ^ temp_s;
        n1_s   = prev_key[95:64]  ^ n0_s;
        n2_s   = prev_key[63:32]  ^ n1_s;
        n3_s   = prev_key[31:0]   ^ n2_s;
        next_key = {n0_s, n1_s, n2_s, n3_s};
    end

endmodule

// File: rtl/aes_decrypt_sequencer.sv
// Iterative AES-128 decryptor: 10-cycle key expansion into a round-key file,
// one whitening cycle, then ten inverse rounds on a single shared datapath.
module aes_decrypt_sequencer
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] cipher_text,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] plain_text,
    output logic         busy
);

    aes_state_e   state_r;
    aes_state_e   state_nx_s;
    logic         accept_s;
    logic         mix_en_s;
    logic [3:0]   rnd_r;
    logic [127:0] ct_r;
    logic [127:0] state_reg_r;
    logic [127:0] rk_r [11];
    logic [127:0] rk_rd_s;
    logic [127:0] next_rk_s;
    logic [127:0] round_out_s;
    logic         in_ready_r;
    logic         out_valid_r;
    logic         busy_r;

    aes_key_expand_step u_key_step (
        .prev_key  (rk_rd_s),
        .round_idx (rnd_r + 4'd1),
        .next_key  (next_rk_s)
    );

    aes_inv_round u_inv_round (
        .state_in  (state_reg_r),
        .round_key (rk_rd_s),
        .mix_en    (mix_en_s),
        .state_out (round_out_s)
    );

    // Next-state decode; one shared round-key read port serves both phases.
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        mix_en_s   = (rnd_r != 4'd0);
        if (rnd_r <= 4'd10) begin
            rk_rd_s = rk_r[rnd_r];
        end else begin
            rk_rd_s = 128'd0;
        end
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    accept_s   = 1'b1;
                    state_nx_s = ST_KEYEXP;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_KEYEXP: begin
                if (rnd_r == 4'd9) begin
                    state_nx_s = ST_INIT;
                end else begin
                    state_nx_s = ST_KEYEXP;
                end
            end
            ST_INIT: state_nx_s = ST_ROUND;
            ST_ROUND: begin
                if (rnd_r == 4'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_ROUND;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Handshake/status outputs registered from the next state so they track state_r.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (state_nx_s == ST_IDLE);
            out_valid_r <= (state_nx_s == ST_DONE);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

    // Round-key file: entry 0 loaded on accept, entries 1..10 filled during KEYEXP.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            rk_r[0] <= key;
        end else if (state_r == ST_KEYEXP) begin
            rk_r[rnd_r + 4'd1] <= next_rk_s;
        end
    end

    // Ciphertext capture, round counter and the cipher state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ct_r        <= 128'd0;
            state_reg_r <= 128'd0;
            rnd_r       <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        ct_r  <= cipher_text;
                        rnd_r <= 4'd0;
                    end
                end
                ST_KEYEXP: rnd_r <= rnd_r + 4'd1;
                ST_INIT: begin
                    state_reg_r <= ct_r ^ rk_rd_s;
                    rnd_r       <= 4'd9;
                end
                ST_ROUND: begin
                    state_reg_r <= round_out_s;
                    if (rnd_r != 4'd0) begin
                        rnd_r <= rnd_r - 4'd1;
                    end
                end
                ST_DONE: rnd_r <= 4'd0;
                default: rnd_r <= 4'd0;
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign plain_text = state_reg_r;

endmodule

// File: tb/tb_aes_decrypt_sequencer.sv
// Scoreboard bench for aes_decrypt_sequencer using the FIPS-197 AES-128 vectors.
module tb_aes_decrypt_sequencer;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] cipher_text;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] plain_text;
    logic         busy;

    int tests_run = 0;
    int fail_cnt  = 0;
    logic [127:0] exp_q [$];

    aes_decrypt_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .cipher_text (cipher_text),
        .key         (key),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .plain_text  (plain_text),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Offer one pair at a negedge while idle; scramble the inputs after the accept.
    task automatic send(input logic [127:0] k, input logic [127:0] c, input logic [127:0] p);
        key = k;
        cipher_text = c;
        in_valid = 1'b1;
        exp_q.push_back(p);
        @(negedge clk);
        in_valid = 1'b0;
        key = ~k;
        cipher_text = ~c;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic pop_exp(output logic [127:0] e);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e = 128'hx;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        key = 128'd0;
        cipher_text = 128'd0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || plain_text !== 128'd0) begin
            fail_cnt++;
            $display("FAIL reset_outputs: out_valid=%b busy=%b pt=%h, want 0 0 0", out_valid, busy, plain_text);
        end
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1) begin
            fail_cnt++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_c1();
        int n;
        logic [127:0] e;
        out_ready = 1'b1;
        send(K1, C1, P1);
        tests_run++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            fail_cnt++;
            $display("FAIL c1_busy_after_accept: busy=%b in_ready=%b want 1 0", busy, in_ready);
        end
        wait_valid(n);
        tests_run++;
        if (n !== 21) begin
            fail_cnt++;
            $display("FAIL c1_latency: got %0d want 21", n);
        end
        pop_exp(e);
        tests_run++;
        if (out_valid !== 1'b1 || plain_text !== e) begin
            fail_cnt++;
            $display("FAIL c1_plain_text: got %h want %h", plain_text, e);
        end
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL c1_return_idle: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_appb();
        int n;
        logic [127:0] e;
        out_ready = 1'b1;
        send(K2, C2, P2);
        wait_valid(n);
        tests_run++;
        if (n !== 21) begin
            fail_cnt++;
            $display("FAIL appb_latency: got %0d want 21", n);
        end
        pop_exp(e);
        tests_run++;
        if (out_valid !== 1'b1 || plain_text !== e) begin
            fail_cnt++;
            $display("FAIL appb_plain_text: got %h want %h", plain_text, e);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n;
        logic [127:0] e;
        logic [127:0] held;
        logic stable;
        out_ready = 1'b0;
        send(K1, C1, P1);
        wait_valid(n);
        pop_exp(e);
        tests_run++;
        if (out_valid !== 1'b1 || plain_text !== e) begin
            fail_cnt++;
            $display("FAIL bp_plain_text: got %h want %h", plain_text, e);
        end
        held = plain_text;
        stable = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (plain_text !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                stable = 1'b0;
            end
        end
        tests_run++;
        if (stable !== 1'b1) begin
            fail_cnt++;
            $display("FAIL bp_hold: stable=%b want 1 (pt=%h in_ready=%b out_valid=%b)", stable, plain_text, in_ready, out_valid);
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        logic [127:0] e;
        out_ready = 1'b1;
        send(K2, C2, P2);
        repeat (12) @(negedge clk);
        key = K1;
        cipher_text = C1;
        in_valid = 1'b1;
        wait_valid(n);
        pop_exp(e);
        tests_run++;
        if (out_valid !== 1'b1 || plain_text !== e) begin
            fail_cnt++;
            $display("FAIL busy_first_result: got %h want %h", plain_text, e);
        end
        exp_q.push_back(P1);
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL busy_not_accepted_early: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        key = 128'd0;
        cipher_text = 128'd0;
        tests_run++;
        if (busy !== 1'b1) begin
            fail_cnt++;
            $display("FAIL busy_second_accept: busy=%b want 1", busy);
        end
        wait_valid(n);
        tests_run++;
        if (n !== 21) begin
            fail_cnt++;
            $display("FAIL busy_second_latency: got %0d want 21", n);
        end
        pop_exp(e);
        tests_run++;
        if (out_valid !== 1'b1 || plain_text !== e) begin
            fail_cnt++;
            $display("FAIL busy_second_result: got %h want %h", plain_text, e);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int n;
        logic [127:0] e;
        logic seen;
        out_ready = 1'b1;
        key = K2;
        cipher_text = C2;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL abort_async: out_valid=%b busy=%b want 0 0", out_valid, busy);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fail_cnt++;
            $display("FAIL abort_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
        end
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid !== 1'b0) begin
                seen = 1'b1;
            end
            @(negedge clk);
        end
        tests_run++;
        if (seen !== 1'b0) begin
            fail_cnt++;
            $display("FAIL abort_no_output: out_valid seen=%b want 0", seen);
        end
        send(K1, C1, P1);
        wait_valid(n);
        pop_exp(e);
        tests_run++;
        if (out_valid !== 1'b1 || plain_text !== e || n !== 21) begin
            fail_cnt++;
            $display("FAIL abort_followup: got %h lat %0d want %h lat 21", plain_text, n, e);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [127:0] kv [3];
        logic [127:0] cv [3];
        logic [127:0] pv [3];
        int acc_t [3];
        int idx;
        int got;
        int t;
        logic pend;
        logic [127:0] e;
        kv[0] = K1; cv[0] = C1; pv[0] = P1;
        kv[1] = K2; cv[1] = C2; pv[1] = P2;
        kv[2] = K1; cv[2] = C1; pv[2] = P1;
        idx = 0;
        got = 0;
        t = 0;
        out_ready = 1'b1;
        key = kv[0];
        cipher_text = cv[0];
        in_valid = 1'b1;
        while (got < 3 && t < 300) begin
            pend = 1'b0;
            if (in_ready === 1'b1 && in_valid === 1'b1 && idx < 3) begin
                acc_t[idx] = t;
                exp_q.push_back(pv[idx]);
                idx++;
                pend = 1'b1;
            end
            @(negedge clk);
            t++;
            if (pend) begin
                if (idx < 3) begin
                    key = kv[idx];
                    cipher_text = cv[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                pop_exp(e);
                tests_run++;
                if (plain_text !== e) begin
                    fail_cnt++;
                    $display("FAIL b2b_result_%0d: got %h want %h", got, plain_text, e);
                end
                got++;
            end
        end
        in_valid = 1'b0;
        tests_run++;
        if (got !== 3 || idx !== 3) begin
            fail_cnt++;
            $display("FAIL b2b_count: results %0d accepts %0d want 3 3", got, idx);
        end else begin
            tests_run++;
            if ((acc_t[1] - acc_t[0]) !== 23 || (acc_t[2] - acc_t[1]) !== 23) begin
                fail_cnt++;
                $display("FAIL b2b_spacing: got %0d %0d want 23 23", acc_t[1] - acc_t[0], acc_t[2] - acc_t[1]);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_c1();
        test_appb();
        test_backpressure();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        tests_run++;
        if (exp_q.size() !== 0) begin
            fail_cnt++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
        $finish;
    end

endmodule
